// File: rtl/cal_pkg.sv
// Shared widths, weekday codes, load-FSM states and calendar helpers for cal_clock_core.
// The optional alarm is enabled by defining CAL_ALARM_EN.
package cal_pkg;

    localparam int YEAR_W = 14;
    localparam int MON_W  = 4;
    localparam int DAY_W  = 5;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int WDAY_W = 3;

    localparam logic [WDAY_W-1:0] WD_MON = 3'd1;
    localparam logic [WDAY_W-1:0] WD_TUE = 3'd2;
    localparam logic [WDAY_W-1:0] WD_WED = 3'd3;
    localparam logic [WDAY_W-1:0] WD_THU = 3'd4;
    localparam logic [WDAY_W-1:0] WD_FRI = 3'd5;
    localparam logic [WDAY_W-1:0] WD_SAT = 3'd6;
    localparam logic [WDAY_W-1:0] WD_SUN = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WDAY  = 2'd2
    } ld_state_e;

    localparam logic [DAY_W-1:0] MONTH_DAYS [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        logic by4;
        logic by100;
        logic by400;
        by4   = ((year % 14'd4)   == 14'd0);
        by100 = ((year % 14'd100) == 14'd0);
        by400 = ((year % 14'd400) == 14'd0);
        return by4 && (!by100 || by400);
    endfunction

    // Out-of-range months report length 0 so any day fails validation.
    function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] month,
                                                   input logic leap);
        logic [DAY_W-1:0] len;
        len = 5'd0;
        if ((month == 4'd2) && leap) begin
            len = 5'd29;
        end else if ((month >= 4'd1) && (month <= 4'd12)) begin
            len = MONTH_DAYS[month - 4'd1];
        end else begin
            len = 5'd0;
        end
        return len;
    endfunction

endpackage

// File: rtl/cal_clock_core_if.sv
// Load handshake and time outputs of cal_clock_core; alarm signals exist only with CAL_ALARM_EN.
interface cal_clock_core_if;
    import cal_pkg::*;

    logic              run;
    logic              ld_valid;
    logic              ld_ready;
    logic [YEAR_W-1:0] ld_year;
    logic [MON_W-1:0]  ld_month;
    logic [DAY_W-1:0]  ld_day;
    logic [HOUR_W-1:0] ld_hour;
    logic [MIN_W-1:0]  ld_min;
    logic [SEC_W-1:0]  ld_sec;
    logic              ld_err;
    logic [YEAR_W-1:0] year;
    logic [MON_W-1:0]  month;
    logic [DAY_W-1:0]  day;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [WDAY_W-1:0] weekday;
    logic              sec_tick;

`ifdef CAL_ALARM_EN
    logic              alarm_on;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              alarm_hit;

    modport master (
        output run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
               alarm_on, alarm_hour, alarm_min,
        input  ld_ready, ld_err, year, month, day, hour, minute, second, weekday,
               sec_tick, alarm_hit
    );

    modport slave (
        input  run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
               alarm_on, alarm_hour, alarm_min,
        output ld_ready, ld_err, year, month, day, hour, minute, second, weekday,
               sec_tick, alarm_hit
    );
`else
    modport master (
        output run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
        input  ld_ready, ld_err, year, month, day, hour, minute, second, weekday,
               sec_tick
    );

    modport slave (
        input  run, ld_valid, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
        output ld_ready, ld_err, year, month, day, hour, minute, second, weekday,
               sec_tick
    );
`endif

endinterface

// File: rtl/cal_weekday.sv
// Combinational Gregorian weekday (Sakamoto), result 1=Mon .. 7=Sun.
module cal_weekday
    import cal_pkg::*;
(
    input  logic [YEAR_W-1:0] year,
    input  logic [MON_W-1:0]  month,
    input  logic [DAY_W-1:0]  day,
    output logic [WDAY_W-1:0] wday
);

    logic [15:0]       y_s;
    logic [15:0]       t_s;
    logic [15:0]       sum_s;
    logic [WDAY_W-1:0] rem_s;

    // Jan/Feb count as months of the previous year; y/4 - y/100 + y/400 adds leap days.
    always_comb begin
        y_s   = 16'd0;
        t_s   = 16'd0;
        sum_s = 16'd0;
        rem_s = 3'd0;
        wday  = WD_SUN;
        case (month)
            4'd1:    t_s = 16'd0;
            4'd2:    t_s = 16'd3;
            4'd3:    t_s = 16'd2;
            4'd4:    t_s = 16'd5;
            4'd5:    t_s = 16'd0;
            4'd6:    t_s = 16'd3;
            4'd7:    t_s = 16'd5;
            4'd8:    t_s = 16'd1;
            4'd9:    t_s = 16'd4;
            4'd10:   t_s = 16'd6;
            4'd11:   t_s = 16'd2;
            4'd12:   t_s = 16'd4;
            default: t_s = 16'd0;
        endcase
        if (month < 4'd3) begin
            y_s = {2'b00, year} - 16'd1;
        end else begin
            y_s = {2'b00, year};
        end
        sum_s = y_s + (y_s / 16'd4) - (y_s / 16'd100) + (y_s / 16'd400) + t_s + {11'd0, day};
        rem_s = 3'(sum_s % 16'd7);
        if (rem_s == 3'd0) begin
            wday = WD_SUN;
        end else begin
            wday = rem_s;
        end
    end

endmodule

// File: rtl/cal_clock_core.sv
// Second-resolution Gregorian calendar clock with validated load handshake.
// Define CAL_ALARM_EN to add the hour:minute alarm.
module cal_clock_core
    import cal_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int YEAR_MIN  = 1,
    parameter int YEAR_MAX  = 9999,
    parameter int RST_YEAR  = 2023,
    parameter int RST_MONTH = 5,
    parameter int RST_DAY   = 9,
    parameter int RST_HOUR  = 11,
    parameter int RST_MIN   = 59,
    parameter int RST_SEC   = 58,
    parameter int RST_WDAY  = 2
)(
    input  logic             clk,
    input  logic             rst,
    cal_clock_core_if.slave  bus
);

    localparam int                PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]  PRE_TC = PRE_W'(CLK_HZ - 1);
    localparam logic [YEAR_W-1:0] YMIN   = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX   = YEAR_W'(YEAR_MAX);

    ld_state_e         state_r, state_n;
    logic [PRE_W-1:0]  presc_r;
    logic [YEAR_W-1:0] year_r,  sh_year_r,  inc_year_s;
    logic [MON_W-1:0]  month_r, sh_month_r, inc_month_s;
    logic [DAY_W-1:0]  day_r,   sh_day_r,   inc_day_s;
    logic [HOUR_W-1:0] hour_r,  sh_hour_r,  inc_hour_s;
    logic [MIN_W-1:0]  min_r,   sh_min_r,   inc_min_s;
    logic [SEC_W-1:0]  sec_r,   sh_sec_r,   inc_sec_s;
    logic [WDAY_W-1:0] wday_r,  inc_wday_s, wday_calc_s;
    logic              ld_ready_r, ld_err_r, sec_tick_r;
    logic              tick_s, capture_s, commit_s, err_s, load_ok_s, step_s;

    assign tick_s = bus.run && (presc_r == PRE_TC);
    // Ticks outside IDLE are dropped, not deferred.
    assign step_s = tick_s && (state_r == ST_IDLE);

    assign load_ok_s = (sh_year_r >= YMIN) && (sh_year_r <= YMAX) &&
                       (sh_month_r >= 4'd1) && (sh_month_r <= 4'd12) &&
                       (sh_day_r >= 5'd1) &&
                       (sh_day_r <= month_len(sh_month_r, is_leap(sh_year_r))) &&
                       (sh_hour_r < 5'd24) && (sh_min_r < 6'd60) && (sh_sec_r < 6'd60);

    cal_weekday u_weekday (
        .year  (sh_year_r),
        .month (sh_month_r),
        .day   (sh_day_r),
        .wday  (wday_calc_s)
    );

    // Load FSM next-state and control strobes.
    always_comb begin
        state_n   = state_r;
        capture_s = 1'b0;
        commit_s  = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.ld_valid && ld_ready_r) begin
                    capture_s = 1'b1;
                    state_n   = ST_CHECK;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (load_ok_s) begin
                    state_n = ST_WDAY;
                end else begin
                    err_s   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WDAY: begin
                commit_s = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // One-second carry chain from seconds up to the year wrap.
    always_comb begin
        inc_year_s  = year_r;
        inc_month_s = month_r;
        inc_day_s   = day_r;
        inc_hour_s  = hour_r;
        inc_min_s   = min_r;
        inc_sec_s   = sec_r;
        inc_wday_s  = wday_r;
        if (sec_r == 6'd59) begin
            inc_sec_s = 6'd0;
            if (min_r == 6'd59) begin
                inc_min_s = 6'd0;
                if (hour_r == 5'd23) begin
                    inc_hour_s = 5'd0;
                    inc_wday_s = (wday_r == WD_SUN) ? WD_MON : (wday_r + 3'd1);
                    if (day_r == month_len(month_r, is_leap(year_r))) begin
                        inc_day_s = 5'd1;
                        if (month_r == 4'd12) begin
                            inc_month_s = 4'd1;
                            inc_year_s  = (year_r == YMAX) ? YMIN : (year_r + 14'd1);
                        end else begin
                            inc_month_s = month_r + 4'd1;
                        end
                    end else begin
                        inc_day_s = day_r + 5'd1;
                    end
                end else begin
                    inc_hour_s = hour_r + 5'd1;
                end
            end else begin
                inc_min_s = min_r + 6'd1;
            end
        end else begin
            inc_sec_s = sec_r + 6'd1;
        end
    end

    // FSM state and handshake status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ld_ready_r <= 1'b1;
            ld_err_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            ld_ready_r <= (state_n == ST_IDLE);
            ld_err_r   <= err_s;
        end
    end

    // Shadow copy of the requested time, validated before it is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_year_r  <= 14'd0;
            sh_month_r <= 4'd0;
            sh_day_r   <= 5'd0;
            sh_hour_r  <= 5'd0;
            sh_min_r   <= 6'd0;
            sh_sec_r   <= 6'd0;
        end else if (capture_s) begin
            sh_year_r  <= bus.ld_year;
            sh_month_r <= bus.ld_month;
            sh_day_r   <= bus.ld_day;
            sh_hour_r  <= bus.ld_hour;
            sh_min_r   <= bus.ld_min;
            sh_sec_r   <= bus.ld_sec;
        end else begin
            sh_year_r  <= sh_year_r;
            sh_month_r <= sh_month_r;
            sh_day_r   <= sh_day_r;
            sh_hour_r  <= sh_hour_r;
            sh_min_r   <= sh_min_r;
            sh_sec_r   <= sh_sec_r;
        end
    end

    // Second prescaler; restarts on commit so a loaded time gets a full second.
    always_ff @(posedge clk) begin
        if (rst || commit_s) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (bus.run) begin
            presc_r <= presc_r + 1'b1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Time-of-day registers: load commit has priority over a second step.
    always_ff @(posedge clk) begin
        if (rst) begin
            year_r     <= YEAR_W'(RST_YEAR);
            month_r    <= MON_W'(RST_MONTH);
            day_r      <= DAY_W'(RST_DAY);
            hour_r     <= HOUR_W'(RST_HOUR);
            min_r      <= MIN_W'(RST_MIN);
            sec_r      <= SEC_W'(RST_SEC);
            wday_r     <= WDAY_W'(RST_WDAY);
            sec_tick_r <= 1'b0;
        end else if (commit_s) begin
            year_r     <= sh_year_r;
            month_r    <= sh_month_r;
            day_r      <= sh_day_r;
            hour_r     <= sh_hour_r;
            min_r      <= sh_min_r;
            sec_r      <= sh_sec_r;
            wday_r     <= wday_calc_s;
            sec_tick_r <= 1'b0;
        end else if (step_s) begin
            year_r     <= inc_year_s;
            month_r    <= inc_month_s;
            day_r      <= inc_day_s;
            hour_r     <= inc_hour_s;
            min_r      <= inc_min_s;
            sec_r      <= inc_sec_s;
            wday_r     <= inc_wday_s;
            sec_tick_r <= 1'b1;
        end else begin
            sec_tick_r <= 1'b0;
        end
    end

`ifdef CAL_ALARM_EN
    logic alarm_hit_r;

    // Alarm fires only on a counted second reaching hh:mm:00, never on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hit_r <= 1'b0;
        end else begin
            alarm_hit_r <= step_s && bus.alarm_on &&
                           (inc_hour_s == bus.alarm_hour) &&
                           (inc_min_s == bus.alarm_min) && (inc_sec_s == 6'd0);
        end
    end

    assign bus.alarm_hit = alarm_hit_r;
`endif

    assign bus.ld_ready = ld_ready_r;
    assign bus.ld_err   = ld_err_r;
    assign bus.sec_tick = sec_tick_r;
    assign bus.year     = year_r;
    assign bus.month    = month_r;
    assign bus.day      = day_r;
    assign bus.hour     = hour_r;
    assign bus.minute   = min_r;
    assign bus.second   = sec_r;
    assign bus.weekday  = wday_r;

endmodule

// File: tb/tb_cal_clock_core.sv
// Directed bench for cal_clock_core with a 4-cycle second; alarm steps need CAL_ALARM_EN.
module tb_cal_clock_core;
    import cal_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks    = 0;
    int   errors    = 0;
    int   tick_cnt  = 0;
    int   alarm_cnt = 0;
    int   t0;
    int   a0;

    cal_clock_core_if bus ();

    cal_clock_core #(.CLK_HZ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sec_tick === 1'b1) tick_cnt++;
`ifdef CAL_ALARM_EN
        if (bus.alarm_hit === 1'b1) alarm_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int y, input int mo, input int d,
                            input int h, input int mi, input int s, input int wd);
        chk({tag, ".year"},    32'(bus.year),    y);
        chk({tag, ".month"},   32'(bus.month),   mo);
        chk({tag, ".day"},     32'(bus.day),     d);
        chk({tag, ".hour"},    32'(bus.hour),    h);
        chk({tag, ".minute"},  32'(bus.minute),  mi);
        chk({tag, ".second"},  32'(bus.second),  s);
        chk({tag, ".weekday"}, 32'(bus.weekday), wd);
    endtask

    task automatic drive_ld(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
        bus.ld_year  = 14'(y);
        bus.ld_month = 4'(mo);
        bus.ld_day   = 5'(d);
        bus.ld_hour  = 5'(h);
        bus.ld_min   = 6'(mi);
        bus.ld_sec   = 6'(s);
    endtask

    // Accepted loads return ld_ready on the 3rd cycle, rejected ones on the 2nd.
    task automatic do_load(input string tag, input int y, input int mo, input int d,
                           input int h, input int mi, input int s, input bit ok);
        int n;
        bit err_seen;
        @(negedge clk);
        drive_ld(y, mo, d, h, mi, s);
        bus.ld_valid = 1'b1;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        n = 0;
        err_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.ld_err === 1'b1) err_seen = 1'b1;
        end while ((bus.ld_ready !== 1'b1) && (n < 10));
        chk({tag, ".latency"}, n, ok ? 3 : 2);
        chk({tag, ".ld_err"}, 32'(err_seen), ok ? 0 : 1);
    endtask

    // Runs exactly one prescaler period from a zeroed prescaler.
    task automatic do_tick(input string tag);
        int c0;
        @(negedge clk);
        c0 = tick_cnt;
        bus.run = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        #1 chk({tag, ".sec_ticks"}, tick_cnt - c0, 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.run      = 1'b0;
        bus.ld_valid = 1'b0;
        drive_ld(0, 0, 0, 0, 0, 0);
`ifdef CAL_ALARM_EN
        bus.alarm_on   = 1'b0;
        bus.alarm_hour = 5'd7;
        bus.alarm_min  = 6'd30;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_time("rst", 2023, 5, 9, 11, 59, 58, 2);
        chk("rst.ld_ready", 32'(bus.ld_ready), 1);
        chk("rst.ld_err",   32'(bus.ld_err),   0);
        chk("rst.sec_tick", 32'(bus.sec_tick), 0);
        rst = 1'b0;

        // Two seconds roll 11:59:58 over to 12:00:00
        #1 t0 = tick_cnt;
        bus.run = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        #1 chk("run2.sec_ticks", tick_cnt - t0, 2);
        chk_time("run2", 2023, 5, 9, 12, 0, 0, 2);

        // Year rollover
        do_load("ld_nye", 2023, 12, 31, 23, 59, 59, 1'b1);
        chk_time("ld_nye", 2023, 12, 31, 23, 59, 59, 7);
        do_tick("tk_nye");
        chk_time("tk_nye", 2024, 1, 1, 0, 0, 0, 1);

        // Leap and non-leap end of February
        do_load("ld_feb24", 2024, 2, 28, 23, 59, 59, 1'b1);
        chk("ld_feb24.weekday", 32'(bus.weekday), 3);
        do_tick("tk_feb24");
        chk_time("tk_feb24", 2024, 2, 29, 0, 0, 0, 4);
        do_load("ld_feb23", 2023, 2, 28, 23, 59, 59, 1'b1);
        chk("ld_feb23.weekday", 32'(bus.weekday), 2);
        do_tick("tk_feb23");
        chk_time("tk_feb23", 2023, 3, 1, 0, 0, 0, 3);

        // Validation: 1900 not leap, 2000 leap, month 13, year 0
        do_load("ld_1900", 1900, 2, 29, 10, 0, 0, 1'b0);
        chk_time("ld_1900", 2023, 3, 1, 0, 0, 0, 3);
        do_load("ld_2000", 2000, 2, 29, 12, 34, 56, 1'b1);
        chk_time("ld_2000", 2000, 2, 29, 12, 34, 56, 2);
        do_load("ld_m13", 2020, 13, 1, 0, 0, 0, 1'b0);
        chk_time("ld_m13", 2000, 2, 29, 12, 34, 56, 2);
        do_load("ld_y0", 0, 1, 1, 0, 0, 0, 1'b0);
        chk("ld_y0.year", 32'(bus.year), 2000);

        // Tick lands while a rejected load (April 31) sits in CHECK: dropped
        @(negedge clk);
        t0 = tick_cnt;
        drive_ld(2000, 4, 31, 1, 2, 3);
        bus.run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.run = 1'b0;
        chk("tkchk.ld_err",   32'(bus.ld_err),   1);
        chk("tkchk.ld_ready", 32'(bus.ld_ready), 1);
        @(negedge clk);
        #1 chk("tkchk.sec_ticks", tick_cnt - t0, 0);
        chk_time("tkchk", 2000, 2, 29, 12, 34, 56, 2);

        // YEAR_MAX wraps to YEAR_MIN
        do_load("ld_max", 9999, 12, 31, 23, 59, 59, 1'b1);
        chk("ld_max.weekday", 32'(bus.weekday), 5);
        do_tick("tk_max");
        chk_time("tk_max", 1, 1, 1, 0, 0, 0, 6);

`ifdef CAL_ALARM_EN
        // Alarm on a counted second, not on a direct load
        bus.alarm_on = 1'b1;
        do_load("ld_al1", 2024, 1, 1, 7, 29, 59, 1'b1);
        #1 a0 = alarm_cnt;
        do_tick("tk_al1");
        chk("tk_al1.alarm_hits", alarm_cnt - a0, 1);
        chk_time("tk_al1", 2024, 1, 1, 7, 30, 0, 1);
        #1 a0 = alarm_cnt;
        do_load("ld_al2", 2024, 1, 1, 7, 30, 0, 1'b1);
        @(negedge clk);
        #1 chk("ld_al2.alarm_hits", alarm_cnt - a0, 0);
        bus.alarm_on = 1'b0;
`endif

        // Reset while the load is in WDAY aborts it
        @(negedge clk);
        drive_ld(2024, 6, 15, 10, 0, 0);
        bus.ld_valid = 1'b1;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw.ld_ready", 32'(bus.ld_ready), 1);
        chk_time("rstw", 2023, 5, 9, 11, 59, 58, 2);
        repeat (2) @(negedge clk);
        chk_time("rstw2", 2023, 5, 9, 11, 59, 58, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
